// File: rtl/mbhd_pkg.sv
// Shared types and defaults for the multi-ball hit detector.
// Optional feature macro: HIT_COOLDOWN_EN (per-channel post-hit cooldown).
package mbhd_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    ARMED    = 2'd0,
    HIT      = 2'd1,
    COOLDOWN = 2'd2
  } ch_state_e;

  // Inclusive span test [lo, lo+size-1] done in 11 bits so a box near the
  // right/bottom edge of the 10-bit coordinate space cannot wrap.
  function automatic logic in_span(input coord_t p, input coord_t lo, input int size);
    logic [10:0] lo_w;
    logic [10:0] hi_w;
    logic [10:0] p_w;
    lo_w = {1'b0, lo};
    hi_w = lo_w + 11'(size - 1);
    p_w  = {1'b0, p};
    return (p_w >= lo_w) && (p_w <= hi_w);
  endfunction

endpackage

// File: rtl/multi_ball_hit_detector_channel.sv
// One ball channel: box compare, saturating pixel accumulator, per-frame
// hit FSM and (with HIT_COOLDOWN_EN) the cooldown frame counter.
module ball_hit_channel
  import mbhd_pkg::*;
#(
  parameter int BALL_SIZE       = 32,
  parameter int HIT_THRESHOLD   = 64,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x_pixel,
  input  logic [9:0] y_pixel,
  input  logic       de,
  input  logic       is_target_color,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic       ball_valid,
  input  logic       frame_end,
  input  logic       score_clear,
  output logic       hit_pulse,
  output logic [9:0] hit_count
);

  localparam logic [10:0] THR = 11'(HIT_THRESHOLD);

  ch_state_e  state;
  logic [9:0] acc;
  logic       in_box;

  assign in_box    = de && in_span(x_pixel, ball_x, BALL_SIZE)
                        && in_span(y_pixel, ball_y, BALL_SIZE);
  assign hit_pulse = (state == HIT);

  // Accumulate target pixels inside the box; emptied every frame boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                      acc <= '0;
    else if (score_clear || !ball_valid || frame_end) acc <= '0;
    else if (in_box && is_target_color && acc != 10'h3FF) acc <= acc + 10'd1;
  end

  // Publish the completed frame's count at the frame boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           hit_count <= '0;
    else if (score_clear) hit_count <= '0;
    else if (frame_end)   hit_count <= acc;
  end

`ifdef HIT_COOLDOWN_EN
  localparam int CW = $clog2(COOLDOWN_FRAMES + 2);
  logic [CW-1:0] cd;

  // Frames left to ignore hits; loaded while in HIT, counted down per frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                     cd <= '0;
    else if (score_clear || !ball_valid)            cd <= '0;
    else if (state == HIT)                          cd <= CW'(COOLDOWN_FRAMES);
    else if (state == COOLDOWN && frame_end && cd != '0) cd <= cd - CW'(1);
  end
`else
  // Cooldown disabled: the parameter is kept only so the port/parameter list
  // is identical in both builds; nothing is generated from it.
  if (COOLDOWN_FRAMES < 0) begin : g_cooldown_unused
  end
`endif

  // Per-channel hit FSM; a hidden or cleared ball is always re-armed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          state <= ARMED;
    else if (score_clear || !ball_valid) state <= ARMED;
    else begin
      case (state)
        ARMED:    if (frame_end && ({1'b0, acc} >= THR)) state <= HIT;
`ifdef HIT_COOLDOWN_EN
        HIT:      state <= COOLDOWN;
        COOLDOWN: if (frame_end && cd <= CW'(1)) state <= ARMED;
`else
        HIT:      state <= ARMED;
`endif
        default:  state <= ARMED;
      endcase
    end
  end

endmodule

// File: rtl/multi_ball_hit_detector.sv
// Top: frame-end detection, NUM_BALLS hit channels, saturating score.
// Optional feature macro: HIT_COOLDOWN_EN (per-channel post-hit cooldown).
module multi_ball_hit_detector
  import mbhd_pkg::*;
#(
  parameter int NUM_BALLS       = 2,
  parameter int BALL_SIZE       = 32,
  parameter int HIT_THRESHOLD   = 64,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int H_ACTIVE        = H_ACTIVE_DEF,
  parameter int V_ACTIVE        = V_ACTIVE_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [9:0]                x_pixel,
  input  logic [9:0]                y_pixel,
  input  logic                      DE,
  input  logic                      is_target_color,
  input  logic [NUM_BALLS-1:0][9:0] ball_x,
  input  logic [NUM_BALLS-1:0][9:0] ball_y,
  input  logic [NUM_BALLS-1:0]      ball_valid,
  input  logic                      score_clear,
  output logic [NUM_BALLS-1:0]      hit_pulse,
  output logic [7:0]                score,
  output logic [NUM_BALLS-1:0][9:0] hit_count
);

  logic       frame_end;
  logic [2:0] hits;
  logic [8:0] score_sum;

  // Frame boundary strobe, one cycle after the last active pixel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) frame_end <= 1'b0;
    else        frame_end <= DE && (x_pixel == 10'(H_ACTIVE - 1))
                               && (y_pixel == 10'(V_ACTIVE - 1));
  end

  for (genvar i = 0; i < NUM_BALLS; i++) begin : g_ch
    ball_hit_channel #(
      .BALL_SIZE       (BALL_SIZE),
      .HIT_THRESHOLD   (HIT_THRESHOLD),
      .COOLDOWN_FRAMES (COOLDOWN_FRAMES)
    ) u_ch (
      .clk             (clk),
      .reset           (reset),
      .x_pixel         (x_pixel),
      .y_pixel         (y_pixel),
      .de              (DE),
      .is_target_color (is_target_color),
      .ball_x          (ball_x[i]),
      .ball_y          (ball_y[i]),
      .ball_valid      (ball_valid[i]),
      .frame_end       (frame_end),
      .score_clear     (score_clear),
      .hit_pulse       (hit_pulse[i]),
      .hit_count       (hit_count[i])
    );
  end

  // Number of channels hitting this cycle.
  always_comb begin
    hits = '0;
    for (int i = 0; i < NUM_BALLS; i++) hits = hits + 3'(hit_pulse[i]);
  end

  assign score_sum = {1'b0, score} + 9'(hits);

  // Saturating score; clear wins over any same-cycle hit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           score <= '0;
    else if (score_clear) score <= '0;
    else                  score <= score_sum[8] ? 8'hFF : score_sum[7:0];
  end

endmodule

// File: tb/tb_multi_ball_hit_detector.sv
// Directed bench for multi_ball_hit_detector. Frames are sparse: only the
// pixels of interest plus the final active pixel are driven with DE=1.
// Expected hit pulses are queued at the last pixel and popped at their due cycle.
module tb_multi_ball_hit_detector;

  localparam int NB = 2, BS = 32, TH = 64, CF = 8, HA = 640, VA = 480;

  logic                clk = 1'b0;
  logic                reset;
  logic [9:0]          x_pixel, y_pixel;
  logic                DE, is_target_color;
  logic [NB-1:0][9:0]  ball_x, ball_y;
  logic [NB-1:0]       ball_valid;
  logic                score_clear;
  logic [NB-1:0]       hit_pulse;
  logic [7:0]          score;
  logic [NB-1:0][9:0]  hit_count;

  multi_ball_hit_detector #(
    .NUM_BALLS(NB), .BALL_SIZE(BS), .HIT_THRESHOLD(TH),
    .COOLDOWN_FRAMES(CF), .H_ACTIVE(HA), .V_ACTIVE(VA)
  ) dut (
    .clk(clk), .reset(reset), .x_pixel(x_pixel), .y_pixel(y_pixel),
    .DE(DE), .is_target_color(is_target_color), .ball_x(ball_x),
    .ball_y(ball_y), .ball_valid(ball_valid), .score_clear(score_clear),
    .hit_pulse(hit_pulse), .score(score), .hit_count(hit_count)
  );

  always #20 clk = ~clk;

  typedef struct {
    int            due;
    logic [NB-1:0] pulse;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0, errors = 0, cyc = 0, npulse0 = 0;
  int   m_acc[NB], m_hc[NB], m_cd[NB], m_score;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < NB; i++) begin m_acc[i] = 0; m_hc[i] = 0; m_cd[i] = 0; end
    m_score = 0;
  endtask

  // One clock; outputs sampled on the falling edge against the scoreboard.
  task automatic step();
    exp_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      chk("hit_pulse", 32'(hit_pulse), 32'(e.pulse));
    end else begin
      chk("no_pulse", 32'(hit_pulse), 32'd0);
    end
    if (hit_pulse[0] === 1'b1) npulse0++;
  endtask

  task automatic pix(input int x, input int y, input bit tgt);
    int bx, by;
    x_pixel = 10'(x); y_pixel = 10'(y); DE = 1'b1; is_target_color = tgt;
    for (int i = 0; i < NB; i++) begin
      bx = int'(ball_x[i]); by = int'(ball_y[i]);
      if (ball_valid[i] && tgt && x >= bx && x <= bx + BS - 1 && y >= by && y <= by + BS - 1
          && m_acc[i] < 1023)
        m_acc[i]++;
    end
    step();
  endtask

  task automatic paint(input int x0, input int y0, input int w, input int h);
    for (int yy = y0; yy < y0 + h; yy++)
      for (int xx = x0; xx < x0 + w; xx++) pix(xx, yy, 1'b1);
  endtask

  task automatic idle(input int n);
    DE = 1'b0; is_target_color = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic clear();
    DE = 1'b0; is_target_color = 1'b0; score_clear = 1'b1;
    step();
    score_clear = 1'b0;
    model_zero();
    step();
    chk("clear_score", 32'(score), 32'd0);
  endtask

  // Last active pixel, expected outcome queued, optional clear on frame_end.
  task automatic end_frame(input bit clr);
    exp_t e;
    int   n;
    pix(HA - 1, VA - 1, 1'b0);
    e.pulse = '0; n = 0;
    for (int i = 0; i < NB; i++) begin
      m_hc[i] = m_acc[i]; m_acc[i] = 0;
      if (!ball_valid[i]) m_cd[i] = 0;
      else if (m_cd[i] > 0) m_cd[i]--;
      else if (m_hc[i] >= TH) begin
        e.pulse[i] = 1'b1; n++;
`ifdef HIT_COOLDOWN_EN
        m_cd[i] = CF;
`endif
      end
    end
    if (clr) begin
      e.pulse = '0; m_score = 0;
      for (int i = 0; i < NB; i++) begin m_hc[i] = 0; m_cd[i] = 0; end
    end else begin
      m_score = (m_score + n > 255) ? 255 : m_score + n;
    end
    e.due = cyc + 1;
    sbq.push_back(e);
    DE = 1'b0; is_target_color = 1'b0; score_clear = clr;
    step();
    score_clear = 1'b0;
    step(); step(); step();
    for (int i = 0; i < NB; i++)
      chk($sformatf("hit_count%0d", i), 32'(hit_count[i]), 32'(m_hc[i]));
    chk("score", 32'(score), 32'(m_score));
    chk("sb_drained", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    int p0;
    reset = 1'b0; DE = 1'b0; x_pixel = '0; y_pixel = '0; is_target_color = 1'b0;
    score_clear = 1'b0;
    ball_x[0] = 10'd100; ball_y[0] = 10'd100;
    ball_x[1] = 10'd300; ball_y[1] = 10'd300;
    ball_valid = '1;
    model_zero();

    // Reset state
    step(); step();
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_hc0", 32'(hit_count[0]), 32'd0);
    chk("rst_hc1", 32'(hit_count[1]), 32'd0);
    reset = 1'b1;
    idle(2);

    // Full 32x32 box plus pixels just outside each edge -> saturated count, hit
    pix(99, 100, 1'b1); pix(132, 100, 1'b1); pix(100, 99, 1'b1); pix(100, 132, 1'b1);
    paint(100, 100, 32, 32);
    end_frame(1'b0);
    chk("t1_hc0_sat", 32'(hit_count[0]), 32'd1023);
    chk("t1_score", 32'(score), 32'd1);

    // Threshold boundary: 56 pixels miss, 64 pixels hit
    clear();
    paint(110, 110, 8, 7);
    end_frame(1'b0);
    chk("t2_hc56", 32'(hit_count[0]), 32'd56);
    paint(110, 110, 8, 8);
    end_frame(1'b0);
    chk("t2_hc64", 32'(hit_count[0]), 32'd64);
    chk("t2_score", 32'(score), 32'd1);

    // Ten consecutive hit frames
    clear();
    p0 = npulse0;
    for (int f = 0; f < 10; f++) begin
      paint(110, 110, 8, 8);
      end_frame(1'b0);
    end
`ifdef HIT_COOLDOWN_EN
    chk("t3_pulses", 32'(npulse0 - p0), 32'd2);
`else
    chk("t3_pulses", 32'(npulse0 - p0), 32'd10);
`endif

    // Two balls in one frame, then drive score to saturation
    clear();
    paint(110, 110, 8, 8); paint(304, 304, 8, 8);
    end_frame(1'b0);
    chk("t4_score2", 32'(score), 32'd2);
    while (m_score < 254) begin
`ifdef HIT_COOLDOWN_EN
      for (int f = 0; f < CF; f++) end_frame(1'b0);
`endif
      paint(110, 110, 8, 8); paint(304, 304, 8, 8);
      end_frame(1'b0);
    end
    chk("t4_score254", 32'(score), 32'd254);
`ifdef HIT_COOLDOWN_EN
    for (int f = 0; f < CF; f++) end_frame(1'b0);
`endif
    paint(110, 110, 8, 8); paint(304, 304, 8, 8);
    end_frame(1'b0);
    chk("t4_score_sat", 32'(score), 32'd255);

    // Clear coincident with a frame_end that would hit
    clear();
    paint(304, 304, 8, 8);
    end_frame(1'b0);
    chk("t5_pre_score", 32'(score), 32'd1);
    paint(110, 110, 8, 8);
    end_frame(1'b1);
    chk("t5_score", 32'(score), 32'd0);
    chk("t5_hc0", 32'(hit_count[0]), 32'd0);

    // Reset in mid-frame at (320,240)
    paint(110, 110, 8, 8);
    end_frame(1'b0);
    chk("t6_pre_score", 32'(score), 32'd1);
    paint(110, 110, 8, 4);
    x_pixel = 10'd320; y_pixel = 10'd240; DE = 1'b1; is_target_color = 1'b1;
    reset = 1'b0;
    #1;
    chk("t6_rst_score", 32'(score), 32'd0);
    chk("t6_rst_pulse", 32'(hit_pulse), 32'd0);
    chk("t6_rst_hc0", 32'(hit_count[0]), 32'd0);
    chk("t6_rst_hc1", 32'(hit_count[1]), 32'd0);
    model_zero();
    step(); step();
    reset = 1'b1;
    idle(1);
    paint(110, 114, 8, 4);
    end_frame(1'b0);
    chk("t6_partial_hc", 32'(hit_count[0]), 32'd32);
    paint(110, 110, 8, 8);
    end_frame(1'b0);
    chk("t6_full_hc", 32'(hit_count[0]), 32'd64);
    chk("t6_score", 32'(score), 32'd1);

    // Hidden ball ignores target pixels
    ball_valid[0] = 1'b0;
    paint(110, 110, 8, 8);
    end_frame(1'b0);
    chk("t7_hc0_invalid", 32'(hit_count[0]), 32'd0);
    chk("t7_score", 32'(score), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_ball_hit_detector.md
MULTI_BALL_HIT_DETECTOR -- requirements
Module: multi_ball_hit_detector

Interface
REQ-001 SHALL have parameter NUM_BALLS, default 2, number of independent ball channels (1..4).
REQ-002 SHALL have parameter BALL_SIZE, default 32, ball bounding-box edge length in pixels.
REQ-003 SHALL have parameter HIT_THRESHOLD, default 64, minimum target-colour pixels per frame inside a box that count as a hit.
REQ-004 SHALL have parameter COOLDOWN_FRAMES, default 8, number of frames a channel ignores hits after a hit.
REQ-005 SHALL have parameters H_ACTIVE, default 640, and V_ACTIVE, default 480, giving active-area size.
REQ-006 SHALL have port clk  input  1  pixel clock (25 MHz), single clock domain.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have ports x_pixel and y_pixel  input  10 each  current VGA pixel coordinates.
REQ-009 SHALL have port DE  input  1  active-video qualifier.
REQ-010 SHALL have port is_target_color  input  1  current pixel matches the target colour.
REQ-011 SHALL have ports ball_x and ball_y  input  NUM_BALLS x 10  top-left box corner for each ball.
REQ-012 SHALL have port ball_valid  input  NUM_BALLS  the ball is on screen and hittable.
REQ-013 SHALL have port score_clear  input  1  synchronous clear of scores and channel state (debounced game_start).
REQ-014 SHALL have port hit_pulse  output  NUM_BALLS  one-cycle hit strobe per ball.
REQ-015 SHALL have port score  output  8  total hits, saturating.
REQ-016 SHALL have port hit_count  output  NUM_BALLS x 10  last completed frame's in-box pixel count per ball.

Function
REQ-017 SHALL treat a pixel as in-box for ball i when DE=1 and ball_x[i] <= x_pixel <= ball_x[i]+BALL_SIZE-1, and the same rule holds for y; the comparison SHALL use 11-bit sums so no wrap-around occurs.
REQ-018 SHALL increment channel i's accumulator each cycle the pixel is in-box for ball i and is_target_color=1; the accumulator is 10 bits and SHALL saturate at 1023.
REQ-019 SHALL register frame_end one cycle after the cycle in which DE=1, x_pixel=H_ACTIVE-1 and y_pixel=V_ACTIVE-1.
REQ-020 SHALL, on the frame_end cycle, copy each accumulator to hit_count and clear the accumulator in that same cycle.
REQ-021 SHALL give each channel its own FSM with states ARMED, HIT, COOLDOWN.
REQ-022 SHALL move ARMED->HIT when frame_end=1, ball_valid=1 and the accumulator >= HIT_THRESHOLD; HIT lasts exactly one cycle, during which hit_pulse[i]=1.
REQ-023 SHALL move HIT->COOLDOWN unconditionally, loading a frame counter with COOLDOWN_FRAMES.
REQ-024 SHALL, in COOLDOWN, decrement the frame counter on each frame_end and return to ARMED when the counter reaches 0; hits SHALL be ignored during COOLDOWN.
REQ-025 SHALL force a channel to ARMED and hold its accumulator at 0 while ball_valid[i]=0.
REQ-026 SHALL increment score by the number of hit_pulse bits set in a cycle, saturating at 255.
REQ-027 SHALL give score_clear priority over hits in the same cycle: it sets score to 0, sets all FSMs to ARMED, and clears accumulators and hit_count.
REQ-028 SHALL have a hit latency of 2 cycles, measured from the last active pixel of the frame to hit_pulse.

Reset
REQ-029 SHALL, while reset=0, asynchronously set: hit_pulse=0, score=0, hit_count=0, accumulators=0, FSMs=ARMED, frame_end=0, cooldown counters=0.
REQ-030 SHALL, when reset is asserted mid-frame, discard the partial frame; after release, accumulation starts at the next in-box pixel.

Configuration
REQ-031 SHALL, with macro HIT_COOLDOWN_EN defined, implement the COOLDOWN state as specified; without the macro, HIT SHALL return directly to ARMED and no cooldown counters SHALL exist.

Structure
REQ-032 SHALL place the FSM state enum, the 10-bit coordinate typedef and the H_ACTIVE/V_ACTIVE defaults in package mbhd_pkg.
REQ-033 SHALL implement one channel (box compare, accumulator, FSM, cooldown) as sub-module ball_hit_channel, instantiated NUM_BALLS times by a generate loop.

Verification
REQ-034 SHALL cover: ball0 at (100,100) with a 32x32 target square fully inside, threshold 64 -> hit_pulse[0] 2 cycles after pixel (639,479), hit_count[0]=1024 saturated to 1023, score=1.
REQ-035 SHALL cover: 8x7 target patch (56 pixels), threshold 64 -> no hit, hit_count=56; 8x8 patch (64 pixels) -> hit.
REQ-036 SHALL cover: a hit repeated on 10 consecutive frames with COOLDOWN_FRAMES=8 -> pulses on frame 1 and frame 10 only (with HIT_COOLDOWN_EN); pulses on all 10 frames without it.
REQ-037 SHALL cover: two balls hit in the same frame -> both pulses in the same cycle, score +2; starting from score=254 -> score 255.
REQ-038 SHALL cover: score_clear coincident with frame_end hit -> score=0, no pulse.
REQ-039 SHALL cover: reset asserted at pixel (320,240) -> all outputs 0; next full frame counts correctly; ball_valid=0 with the target present -> no hit, hit_count=0.
